uart_rx_fifo: RTL

//  Receive FIFO directly downstream of uart_rx_top. Captures each received character (8b data plus
//  pe/fe/bi status) on the receiver's push strobe, buffers up to DEPTH entries, presents head entry

---
 rtl/uart_rx_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO: 11b entries (bi,fe,pe,data), show-ahead head, level/trigger/overrun/error status.
// Optional character timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_pulse,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pe_in,
  input  logic                     fe_in,
  input  logic                     bi_in,
  input  logic                     pop,
  input  logic                     clr,
  input  logic                     ovr_clr,
  input  logic [1:0]               trig_lvl,
  output logic [7:0]               dout,
  output logic                     pe_out,
  output logic                     fe_out,
  output logic                     bi_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     trig_hit,
  output logic                     overrun,
  output logic                     err_pending,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   err_cnt;
  logic [10:0]   mem [DEPTH];
  logic [10:0]   head;
  logic [31:0]   thresh;
  logic          push_ok;
  logic          pop_ok;
  logic          push_err;
  logic          pop_err;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign head     = mem[rd_ptr[AW-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push & (~full | pop);
  assign pop_ok   = pop & ~empty;
  assign push_err = push_ok & (pe_in | fe_in | bi_in);
  assign pop_err  = pop_ok & (|head[10:8]);

  assign dout     = empty ? 8'h00 : head[7:0];
  assign pe_out   = ~empty & head[8];
  assign fe_out   = ~empty & head[9];
  assign bi_out   = ~empty & head[10];

  always_comb begin
    thresh = 32'd1;
    case (trig_lvl)
      2'b00:   thresh = 32'd1;
      2'b01:   thresh = 32'd4;
      2'b10:   thresh = 32'd8;
      default: thresh = 32'd14;
    endcase
  end

  assign trig_hit    = (32'(count) >= thresh);
  assign err_pending = (err_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst && !clr && push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {bi_in, fe_in, pe_in, din};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_err, pop_err})
        2'b10:   err_cnt <= err_cnt + 1'b1;
        2'b01:   err_cnt <= err_cnt - 1'b1;
        default: err_cnt <= err_cnt;
      endcase
    end
  end

  // A dropped push outranks ovr_clr; clr leaves the sticky flag alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (push && full && !pop && !clr) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else if (clr || push_ok || pop_ok || empty) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (baud_pulse && tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_cnt == TMO_MAX)               tmo_q   <= 1'b1;
    end
  end

  assign timeout = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = baud_pulse & (TIMEOUT_TICKS != 0);
  assign timeout    = 1'b0;
`endif

endmodule
